// File: rtl/vector_accel_defs.sv
// Shared definitions for the vector accelerator: loader state encodings and the
// default element/vector sizes also used by the dotProduct instantiations.
package vector_accel_defs;

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] SEND   = 2'd3;

    localparam int DEF_INTSIZE    = 8;
    localparam int DEF_MATRIXSIZE = 10;

    typedef enum logic [1:0] {
        S_LOAD_A = LOAD_A,
        S_LOAD_B = LOAD_B,
        S_WAIT   = WAIT,
        S_SEND   = SEND
    } loader_state_t;

endpackage

// File: rtl/vector_loader.sv
// Byte-serial loader for the dot-product stage: assembles vectors A and B,
// waits out the downstream latency, then returns the captured result.
//
// state  | meaning
// LOAD_A | accepting elements of A into a_flat
// LOAD_B | accepting elements of B into b_flat
// WAIT   | counting down the dotProduct pipeline latency
// SEND   | holding out_data/out_valid until out_ready
module vector_loader
    import vector_accel_defs::*;
#(
    parameter int MATRIXSIZE = DEF_MATRIXSIZE,
    parameter int INTSIZE    = DEF_INTSIZE,
    parameter int DP_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [INTSIZE-1:0]              in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [0:INTSIZE*MATRIXSIZE-1]   a_flat,
    output logic [0:INTSIZE*MATRIXSIZE-1]   b_flat,
    input  logic [INTSIZE-1:0]              dp_result,
    output logic [INTSIZE-1:0]              out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy
);

    localparam int IDX_W  = (MATRIXSIZE > 1) ? $clog2(MATRIXSIZE) : 1;
    localparam int WAIT_W = $clog2(DP_LATENCY) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(MATRIXSIZE - 1);
    localparam logic [WAIT_W-1:0] WAIT_START = WAIT_W'(DP_LATENCY - 1);

    loader_state_t     state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              out_valid_nxt;
    logic              capture;
    logic              a_we, b_we;
    logic              armed;
    logic              xfer;

    // armed keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    assign in_ready = armed && ((state == S_LOAD_A) || (state == S_LOAD_B));
    assign xfer     = in_valid && in_ready;
    assign busy     = !((state == S_LOAD_A) && (idx == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD_A;
            idx       <= '0;
            wait_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            wait_cnt  <= wait_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        wait_nxt      = wait_cnt;
        out_valid_nxt = out_valid;
        capture       = 1'b0;
        a_we          = 1'b0;
        b_we          = 1'b0;
        if (flush) begin
            state_nxt     = S_LOAD_A;
            idx_nxt       = '0;
            out_valid_nxt = 1'b0;
        end else begin
            case (state)
                S_LOAD_A: begin
                    if (xfer) begin
                        a_we = 1'b1;
                        if (idx == LAST_IDX) begin
                            idx_nxt   = '0;
                            state_nxt = S_LOAD_B;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (xfer) begin
                        b_we = 1'b1;
                        if (idx == LAST_IDX) begin
                            idx_nxt   = '0;
                            wait_nxt  = WAIT_START;
                            state_nxt = S_WAIT;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        capture       = 1'b1;
                        out_valid_nxt = 1'b1;
                        state_nxt     = S_SEND;
                    end else begin
                        wait_nxt = wait_cnt - WAIT_W'(1);
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid_nxt = 1'b0;
                        state_nxt     = S_LOAD_A;
                    end
                end
                default: state_nxt = S_LOAD_A;
            endcase
        end
    end

    // Vectors are only ever written by transfers; flush and later states leave them intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_flat   <= '0;
            b_flat   <= '0;
            out_data <= '0;
        end else begin
            if (a_we)    a_flat[int'(idx) * INTSIZE +: INTSIZE] <= in_data;
            if (b_we)    b_flat[int'(idx) * INTSIZE +: INTSIZE] <= in_data;
            if (capture) out_data <= dp_result;
        end
    end

endmodule

// File: tb/tb_vector_loader.sv
// Scoreboard bench for vector_loader with a registered dot-product model
// standing in for the downstream stage.
module tb_vector_loader;

    localparam int MS = 3;
    localparam int IS = 8;
    localparam int DL = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [IS-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [0:IS*MS-1]  a_flat;
    logic [0:IS*MS-1]  b_flat;
    logic [IS-1:0]     dp_result;
    logic [IS-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IS-1:0] exp_q[$];

    vector_loader #(.MATRIXSIZE(MS), .INTSIZE(IS), .DP_LATENCY(DL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .a_flat(a_flat), .b_flat(b_flat), .dp_result(dp_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [IS-1:0] dot(input logic [0:IS*MS-1] a, input logic [0:IS*MS-1] b);
        int sum = 0;
        for (int i = 0; i < MS; i++) sum += int'(a[i*IS +: IS]) * int'(b[i*IS +: IS]);
        return IS'(sum);
    endfunction

    // Downstream dotProduct: one register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_result <= '0;
        else        dp_result <= dot(a_flat, b_flat);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake completes on the next edge whenever both are high here
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                else                   chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [IS-1:0] v, input int gap);
        int budget = 60;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [IS-1:0] a0, a1, a2, b0, b1, b2,
                        input logic [IS-1:0] exp, input int max_gap);
        logic [IS-1:0] v[6];
        v = '{a0, a1, a2, b0, b1, b2};
        for (int i = 0; i < 6; i++)
            send_elem(v[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        exp_q.push_back(exp);
    endtask

    task automatic wait_out_valid();
        int budget = 20;
        while (!out_valid && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int budget = 40;
        while ((busy || out_valid) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_a_flat", 32'(a_flat), 32'h0);
        chk("rst_b_flat", 32'(b_flat), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("in_ready_after_rst", 32'(in_ready), 32'h1);

        // Continuous stream with latency check
        out_ready = 1'b1;
        load(1, 2, 3, 4, 5, 6, 8'h20, 0);
        chk("t1_a_flat", 32'(a_flat), 32'h010203);
        chk("t1_b_flat", 32'(b_flat), 32'h040506);
        chk("t1_in_ready_wait", 32'(in_ready), 32'h0);
        chk("t1_valid_e0", 32'(out_valid), 32'h0);
        tick();
        chk("t1_valid_e1", 32'(out_valid), 32'h0);
        tick();
        chk("t1_valid_e2", 32'(out_valid), 32'h1);
        chk("t1_data_e2", 32'(out_data), 32'h20);
        tick();
        chk("t1_valid_after_hs", 32'(out_valid), 32'h0);
        chk("t1_in_ready_after_hs", 32'(in_ready), 32'h1);

        // Wrap-around and back-to-back
        load(16, 16, 0, 16, 16, 0, 8'h00, 0);
        load(2, 2, 2, 3, 3, 3, 8'h12, 0);
        wait_idle();
        chk("t2_a_flat", 32'(a_flat), 32'h020202);

        // Random gaps
        load(1, 2, 3, 4, 5, 6, 8'h20, 4);
        chk("t3_a_flat", 32'(a_flat), 32'h010203);
        chk("t3_b_flat", 32'(b_flat), 32'h040506);
        wait_idle();

        // Back-pressure in SEND
        out_ready = 1'b0;
        load(1, 1, 1, 2, 2, 2, 8'h06, 0);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 8'hFF;
            chk("t4_hold_valid", 32'(out_valid), 32'h1);
            chk("t4_hold_data", 32'(out_data), 32'h06);
            chk("t4_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_valid_drop", 32'(out_valid), 32'h0);
        chk("t4_a_flat", 32'(a_flat), 32'h010101);
        chk("t4_b_flat", 32'(b_flat), 32'h020202);

        // Reset in the middle of LOAD_B
        send_elem(7, 0); send_elem(8, 0); send_elem(9, 0);
        send_elem(1, 0); send_elem(2, 0);
        chk("t5_busy_pre", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_a_flat", 32'(a_flat), 32'h0);
        chk("t5_b_flat", 32'(b_flat), 32'h0);
        chk("t5_out_data", 32'(out_data), 32'h0);
        chk("t5_out_valid", 32'(out_valid), 32'h0);
        chk("t5_in_ready", 32'(in_ready), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        load(1, 1, 1, 1, 1, 1, 8'h03, 0);
        wait_idle();

        // Flush during LOAD_B with a coincident element
        send_elem(9, 0); send_elem(9, 0); send_elem(9, 0);
        send_elem(9, 0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_b_flat", 32'(b_flat), 32'h090101);
        chk("t6_out_valid", 32'(out_valid), 32'h0);
        load(5, 0, 0, 5, 0, 0, 8'h19, 0);
        wait_idle();
        chk("t6_a_flat", 32'(a_flat), 32'h050000);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vector_loader.md
Name: vector_loader

Overview:
- Upstream stage of the dot-product datapath.
- Accepts a byte-serial element stream from the host-interface side over a valid/ready handshake and assembles vectors A and B into flattened registers that drive the dotProduct stage's a_flat/b_flat.
- After the downstream stage's latency, captures its result and presents it on a valid/ready output handshake for return to the host.

Parameters:
- MATRIXSIZE, 10, elements per vector; must be >= 1.
- INTSIZE, 8, bits per element and per result.
- DP_LATENCY, 2, WAIT cycles between last B element and result capture; must be >= 2 (1 loader register + 1 downstream register).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the current transaction.
- in_data  input  INTSIZE  incoming element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept in_data.
- a_flat  output  INTSIZE*MATRIXSIZE  vector A; element i at bits [i*INTSIZE +: INTSIZE] of an ascending [0:W-1] vector.
- b_flat  output  INTSIZE*MATRIXSIZE  vector B; same layout as a_flat.
- dp_result  input  INTSIZE  result from dot-product stage.
- out_data  output  INTSIZE  captured result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in any state other than LOAD_A with idx==0.

Behaviour:
- Reset (rst_n low, async):
  - state=LOAD_A, idx=0, wait_cnt=0.
  - a_flat=0, b_flat=0, out_data=0, out_valid=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after deassertion.
- A transfer occurs on a rising edge where in_valid && in_ready. No transfer occurs when in_valid is low; gaps of any length are legal.
- States:
  - LOAD_A:
    - in_ready=1.
    - Each transfer writes element idx of a_flat; idx++.
    - Transfer with idx==MATRIXSIZE-1 -> idx=0, go to LOAD_B.
  - LOAD_B:
    - in_ready=1.
    - Each transfer writes element idx of b_flat; idx++.
    - Transfer with idx==MATRIXSIZE-1 -> idx=0, wait_cnt=DP_LATENCY-1, go to WAIT.
  - WAIT:
    - in_ready=0.
    - wait_cnt decrements each cycle.
    - On the edge where wait_cnt==0: out_data<=dp_result, out_valid<=1, go to SEND.
  - SEND:
    - in_ready=0.
    - out_valid and out_data are held stable until out_ready is sampled high.
    - On that edge: out_valid<=0, go to LOAD_A.
- Latency: the last B transfer at edge E0 gives out_valid high after edge E(DP_LATENCY). With the default, the result is visible 2 cycles after the last B transfer.
- a_flat/b_flat are written only by transfers. They hold their values through WAIT, SEND, flush and later LOAD_A cycles until each element is overwritten. Elements not yet rewritten keep their previous-transaction values.
- Unwritten elements of a partially loaded vector keep their previous values.
- Elements are stored unmodified; no arithmetic is done in this block. out_data is dp_result verbatim, already wrapped mod 2^INTSIZE downstream.
- flush (sync, highest priority after reset):
  - Next state=LOAD_A, idx=0, out_valid=0.
  - Vectors are not cleared.
  - A transfer coincident with flush is discarded.
- MATRIXSIZE==1: each LOAD state accepts exactly one element.
- Reset asserted mid-transaction: immediate return to reset values. A pending out_valid is dropped.
- out_ready high outside SEND is ignored.

Decomposition:
- Shared package/header vector_accel_defs: state encodings (LOAD_A, LOAD_B, WAIT, SEND as 2-bit localparams) and the default INTSIZE/MATRIXSIZE, also used by dotProduct instantiations.
- idx width is $clog2(MATRIXSIZE) with a minimum of 1; wait_cnt width is $clog2(DP_LATENCY)+1.
- No sub-module is needed; the element write uses an indexed part-select.

Test Plan (bench instantiates vector_loader feeding dotProduct, MATRIXSIZE=3, INTSIZE=8, DP_LATENCY=2 unless stated):
- Stream A=1,2,3 then B=4,5,6 with continuous in_valid and out_ready=1 -> a_flat=0x010203, b_flat=0x040506; out_valid rises 2 cycles after the last transfer with out_data=0x20 (32); in_ready returns the cycle after the output handshake.
- A=16,16,0; B=16,16,0 -> out_data=0x00 (512 wraps mod 256); second back-to-back transaction A=2,2,2, B=3,3,3 -> out_data=0x12.
- Random in_valid gaps of 0-4 cycles during load -> identical results to the continuous case; idx advances only on transfers.
- out_ready held low for 5 cycles in SEND -> out_valid=1 and out_data stable throughout; in_ready=0; further in_valid pulses are ignored; completes on the first out_ready high.
- rst_n pulsed low after 2 B elements -> all outputs 0 asynchronously; a fresh A=1,1,1, B=1,1,1 -> out_data=3.
- flush asserted during LOAD_B with coincident in_valid -> that element is discarded; state=LOAD_A, idx=0; the next full load A=5,0,0, B=5,0,0 -> out_data=25.
